if_id_pipe: RTL and testbench

Parametrised IF/ID pipeline stage. It carries the fetched PC, the instruction word and a fetch-fault flag from fetch to decode. It adds what a plain IF/ID register lacks: a valid/ready handshake on both sides, a 2-entry skid buffer so `in_ready_o` is fully registered, a flush input for branch/jump redirect, and NOP injection on empty or flushed slots. It sits between the fetch unit and the decoder.

---
 rtl/if_id_pipe.sv | 134 +++++++++++++
 tb/tb_if_id_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: a 2-entry skid buffer between fetch and decode with flush,
// NOP injection on empty slots and a fully registered in_ready_o.
module if_id_pipe #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      ILEN     = 32,
  parameter logic [ILEN-1:0]  NOP_INST = 32'h00000013,
  parameter logic [XLEN-1:0]  RST_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] inst_i,
  input  logic            fault_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] inst_o,
  output logic            fault_o
);

  // Encoding is {M.valid, S.valid}, so both handshake outputs are plain register bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] m_pc, s_pc;
  logic [ILEN-1:0] m_inst, s_inst;
  logic            m_fault, s_fault;

  logic accept, drain;
  logic load_m_in, load_m_skid, clear_m;
  logic load_s_in, clear_s;

  // A beat moves on a side only in a cycle where both valid and ready are high;
  // a valid beat holds its fields stable until it is taken.
  assign in_ready_o  = ~state_q[0];
  assign out_valid_o = state_q[1];
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = out_valid_o & out_ready_i;

  assign pc_o    = m_pc;
  assign inst_o  = m_inst;
  assign fault_o = m_fault;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    clear_m     = 1'b0;
    load_s_in   = 1'b0;
    clear_s     = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
      clear_m = 1'b1;
      clear_s = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_m_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_m_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_s_in = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
            clear_m = 1'b1;
          end
        end
        FULL: begin
          if (drain) begin
            state_d     = ONE;
            load_m_skid = 1'b1;
            clear_s     = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
          clear_m = 1'b1;
          clear_s = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_pc    <= RST_PC;
      m_inst  <= NOP_INST;
      m_fault <= 1'b0;
      s_pc    <= RST_PC;
      s_inst  <= NOP_INST;
      s_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_m) begin
        m_pc    <= RST_PC;
        m_inst  <= NOP_INST;
        m_fault <= 1'b0;
      end else if (load_m_in) begin
        m_pc    <= pc_i;
        m_inst  <= inst_i;
        m_fault <= fault_i;
      end else if (load_m_skid) begin
        m_pc    <= s_pc;
        m_inst  <= s_inst;
        m_fault <= s_fault;
      end
      if (clear_s) begin
        s_pc    <= RST_PC;
        s_inst  <= NOP_INST;
        s_fault <= 1'b0;
      end else if (load_s_in) begin
        s_pc    <= pc_i;
        s_inst  <= inst_i;
        s_fault <= fault_i;
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: a capacity-2 FIFO model checked every cycle, plus directed
// scenarios pinned with literal expectations and a randomized run.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic        fault_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fault_o;

  if_id_pipe dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .fault_i(fault_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .fault_o(fault_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic        chk_en = 1'b0;
  logic [64:0] exp_q[$];
  logic        hold = 1'b0;
  logic [64:0] last_word = '0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of capacity 2; ready means "not full" as seen before the edge.
  always @(posedge clk) begin
    int n;
    n = exp_q.size();
    hold = chk_en && (n > 0) && !out_ready_i && !flush_i && !rst;
    if (rst || flush_i) begin
      exp_q.delete();
    end else begin
      if ((n > 0) && out_ready_i) void'(exp_q.pop_front());
      if (in_valid_i && (n < 2)) exp_q.push_back({pc_i, inst_i, fault_i});
    end
  end

  always @(negedge clk) begin
    logic [64:0] w;
    logic        v;
    if (chk_en) begin
      v = (exp_q.size() > 0);
      w = v ? exp_q[0] : {32'h0, NOP, 1'b0};
      check("model_out_valid", 65'(out_valid_o), 65'(v));
      check("model_in_ready", 65'(in_ready_o), 65'(exp_q.size() < 2));
      check("model_pc", 65'(pc_o), 65'(w[64:33]));
      check("model_inst", 65'(inst_o), 65'(w[32:1]));
      check("model_fault", 65'(fault_o), 65'(w[0]));
      if (hold) check("stable_while_stalled", {pc_o, inst_o, fault_o}, last_word);
    end
    last_word = {pc_o, inst_o, fault_o};
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic f);
    in_valid_i = v;
    pc_i       = pc;
    inst_i     = inst;
    fault_i    = f;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic f, input logic rdy);
    check({name, "_valid"}, 65'(out_valid_o), 65'(v));
    check({name, "_pc"}, 65'(pc_o), 65'(pc));
    check({name, "_inst"}, 65'(inst_o), 65'(inst));
    check({name, "_fault"}, 65'(fault_o), 65'(f));
    check({name, "_ready"}, 65'(in_ready_o), 65'(rdy));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    expect_out("reset", 1'b0, 32'h0, NOP, 1'b0, 1'b1);

    // Streaming, one beat per cycle
    out_ready_i = 1'b1;
    drive(1'b1, 32'h00, 32'hA, 1'b0); tick();
    expect_out("stream0", 1'b1, 32'h00, 32'hA, 1'b0, 1'b1);
    drive(1'b1, 32'h04, 32'hB, 1'b0); tick();
    expect_out("stream1", 1'b1, 32'h04, 32'hB, 1'b0, 1'b1);
    drive(1'b1, 32'h08, 32'hC, 1'b0); tick();
    expect_out("stream2", 1'b1, 32'h08, 32'hC, 1'b0, 1'b1);
    idle(); tick();
    expect_out("stream_end", 1'b0, 32'h0, NOP, 1'b0, 1'b1);

    // Backpressure
    out_ready_i = 1'b0;
    drive(1'b1, 32'h100, 32'h1100, 1'b0); tick();
    expect_out("bp_one", 1'b1, 32'h100, 32'h1100, 1'b0, 1'b1);
    drive(1'b1, 32'h104, 32'h1104, 1'b0); tick();
    expect_out("bp_full", 1'b1, 32'h100, 32'h1100, 1'b0, 1'b0);
    idle(); tick();
    expect_out("bp_hold", 1'b1, 32'h100, 32'h1100, 1'b0, 1'b0);
    out_ready_i = 1'b1; tick();
    expect_out("bp_drain1", 1'b1, 32'h104, 32'h1104, 1'b0, 1'b1);
    tick();
    expect_out("bp_drain2", 1'b0, 32'h0, NOP, 1'b0, 1'b1);

    // Flush from FULL while 0x300 is presented
    out_ready_i = 1'b0;
    drive(1'b1, 32'h200, 32'h2200, 1'b0); tick();
    drive(1'b1, 32'h204, 32'h2204, 1'b0); tick();
    expect_out("fl_full", 1'b1, 32'h200, 32'h2200, 1'b0, 1'b0);
    drive(1'b1, 32'h300, 32'h3300, 1'b0); flush_i = 1'b1; tick();
    flush_i = 1'b0;
    expect_out("fl_empty", 1'b0, 32'h0, NOP, 1'b0, 1'b1);
    out_ready_i = 1'b1;
    drive(1'b1, 32'h400, 32'h4400, 1'b0); tick();
    expect_out("fl_next", 1'b1, 32'h400, 32'h4400, 1'b0, 1'b1);
    idle(); tick();

    // Flush from ONE discards a beat accepted in the same cycle
    out_ready_i = 1'b0;
    drive(1'b1, 32'h600, 32'h6600, 1'b0); tick();
    drive(1'b1, 32'h604, 32'h6604, 1'b0); flush_i = 1'b1; tick();
    flush_i = 1'b0; idle();
    expect_out("fl_one", 1'b0, 32'h0, NOP, 1'b0, 1'b1);
    tick();
    expect_out("fl_one_after", 1'b0, 32'h0, NOP, 1'b0, 1'b1);

    // Bubbles with fault on 0x10
    out_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h10, 32'h1010, 1'b1); tick();
      expect_out("bub_fault", 1'b1, 32'h10, 32'h1010, 1'b1, 1'b1);
      idle(); tick();
      expect_out("bub_idle1", 1'b0, 32'h0, NOP, 1'b0, 1'b1);
      drive(1'b1, 32'h14, 32'h1414, 1'b0); tick();
      expect_out("bub_clean", 1'b1, 32'h14, 32'h1414, 1'b0, 1'b1);
      idle(); tick();
      expect_out("bub_idle2", 1'b0, 32'h0, NOP, 1'b0, 1'b1);
    end

    // Reset mid-stream with both slots full
    out_ready_i = 1'b0;
    drive(1'b1, 32'h500, 32'h5500, 1'b0); tick();
    drive(1'b1, 32'h504, 32'h5504, 1'b0); tick();
    expect_out("rst_full", 1'b1, 32'h500, 32'h5500, 1'b0, 1'b0);
    rst = 1'b1; flush_i = 1'b1; tick();
    expect_out("rst_mid1", 1'b0, 32'h0, NOP, 1'b0, 1'b1);
    flush_i = 1'b0; tick();
    rst = 1'b0; idle(); tick();
    expect_out("rst_mid2", 1'b0, 32'h0, NOP, 1'b0, 1'b1);

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic r;
      drive(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
            1'($urandom_range(0, 1)));
      out_ready_i = 1'($urandom_range(0, 1));
      flush_i     = ($urandom_range(0, 99) < 5);
      rst         = ($urandom_range(0, 299) == 0);
      if ((cyc % 16) == 0) begin
        r = in_ready_o;
        out_ready_i = ~out_ready_i;
        #1;
        check("ready_no_comb_path", 65'(in_ready_o), 65'(r));
        out_ready_i = ~out_ready_i;
      end
      tick();
    end
    rst = 1'b0; flush_i = 1'b0; idle();
    out_ready_i = 1'b1;
    tick(); tick(); tick();
    expect_out("final_drained", 1'b0, 32'h0, NOP, 1'b0, 1'b1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
